iter_mult_unit: RTL and testbench

Iterative 32x32 -> 64-bit shift-add multiplier in the execute stage. It is the responder side of the execute stage's multiply-start / multiply-done handshake. It has no adder of its own: during a multiply it borrows the execute ALU through `alu_a`/`alu_b`/`alu_f` and reads back `alu_y`. The result is held in `hi`/`lo` for the MFHI/MFLO writeback select.

---
 rtl/iter_mult_unit_pkg.sv | 23 ++
 rtl/iter_mult_unit_ctrl.sv | 92 +++++++++
 rtl/iter_mult_unit.sv | 104 ++++++++++
 tb/tb_iter_mult_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_mult_unit_pkg.sv
// Shared definitions for the iterative multiplier: ALU control codes, cycle count, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package iter_mult_unit_pkg;

  // Execute-stage ALU control codes
  localparam logic [2:0] ALU_CTL_AND = 3'b000;
  localparam logic [2:0] ALU_CTL_OR  = 3'b001;
  localparam logic [2:0] ALU_CTL_ADD = 3'b010;
  localparam logic [2:0] ALU_CTL_SUB = 3'b110;
  localparam logic [2:0] ALU_CTL_SLT = 3'b111;

  // One shift-add step per multiplier bit
  localparam int MULT_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_t;

endpackage

// File: rtl/iter_mult_unit_ctrl.sv
// Control FSM for the iterative multiplier: state register, step counter, status decode.
// Latency: accept -> CYCLES RUN cycles -> 1 FIX cycle -> 1 DONE cycle.
// Backpressure: none; start is only accepted in IDLE, ignored otherwise (no queueing).
//
// Ports:
//   clk, rst        clock, async active-low reset
//   start, abort    request / flush from the execute stage
//   busy            RUN, FIX or DONE
//   done            one-cycle pulse in DONE
//   alu_own         high during RUN (multiplier drives the ALU inputs)
//   accept          start taken this cycle (load operands)
//   load_result     FIX cycle not being flushed (write hi/lo)
module mult_ctrl_fsm
  import iter_mult_unit_pkg::*;
#(
  parameter int CYCLES = MULT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic alu_own,
  output logic accept,
  output logic load_result
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  mult_state_t state, state_nxt;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count <= '0;
      end else if (state == ST_RUN) begin
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    alu_own     = 1'b0;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state)
      ST_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        alu_own = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (count == LAST) begin
          state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          load_result = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
      ST_DONE: begin
        // result is already committed; a flush here cannot cancel it
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/iter_mult_unit.sv
// Iterative WIDTHxWIDTH -> 2*WIDTH shift-add multiplier borrowing the execute ALU for its adds.
// Latency: fixed; start sampled at edge N, done pulses in cycle N+34 (WIDTH=32).
// Backpressure: none; start ignored while busy, abort cancels an in-flight multiply.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   start, sgn, abort   request, signed select, execute-stage flush
//   src_a, src_b        multiplicand, multiplier
//   alu_y               execute ALU result
//   alu_a, alu_b, alu_f ALU operands/control driven while alu_own=1
//   alu_own, busy, done status
//   hi, lo              product high/low words, held until the next completed multiply
module iter_mult_unit
  import iter_mult_unit_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] ALU_ADD = ALU_CTL_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic             abort,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  output logic             alu_own,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic accept;
  logic load_result;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               neg;
  logic               carry;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fixed;

  // Two's-complement magnitude; 0x80..0 maps to itself and is correct read as unsigned
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  mult_ctrl_fsm #(
    .CYCLES (WIDTH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .alu_own     (alu_own),
    .accept      (accept),
    .load_result (load_result)
  );

  // Operands are zero whenever the ALU is not ours so the shared mux sees a quiet bus
  assign alu_a = alu_own ? acc_hi : '0;
  assign alu_b = (alu_own && acc_lo[0]) ? mcand : '0;
  assign alu_f = ALU_ADD;

  // Sum wrapped iff the ALU result is smaller than the addend already in acc_hi
  assign carry = (alu_y < acc_hi);

  assign prod       = {acc_hi, acc_lo};
  assign prod_fixed = neg ? (~prod + 1'b1) : prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
    end else if (accept) begin
      mcand  <= magnitude(src_a, sgn);
      acc_hi <= '0;
      acc_lo <= magnitude(src_b, sgn);
      neg    <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
    end else if (alu_own) begin
      // Multiplier bits shift out of acc_lo as product bits shift in from the sum
      {acc_hi, acc_lo} <= {carry, alu_y, acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (load_result) begin
      {hi, lo} <= prod_fixed;
    end
  end

endmodule

// File: tb/tb_iter_mult_unit.sv
module tb_iter_mult_unit;
  import iter_mult_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [W-1:0] alu_y;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_f;
  logic         alu_own;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Execute-stage ALU the multiplier borrows
  always_comb begin
    alu_y = '0;
    case (alu_f)
      ALU_CTL_ADD: alu_y = alu_a + alu_b;
      ALU_CTL_SUB: alu_y = alu_a - alu_b;
      ALU_CTL_AND: alu_y = alu_a & alu_b;
      ALU_CTL_OR:  alu_y = alu_a | alu_b;
      ALU_CTL_SLT: alu_y = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default:     alu_y = '0;
    endcase
  end

  iter_mult_unit #(
    .WIDTH   (W),
    .ALU_ADD (ALU_CTL_ADD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .abort   (abort),
    .src_a   (src_a),
    .src_b   (src_b),
    .alu_y   (alu_y),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_f   (alu_f),
    .alu_own (alu_own),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it until done (bounded); lat=0 means no done seen
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output int own);
    src_a = a;
    src_b = b;
    sgn   = s;
    start = 1'b1;
    lat   = 0;
    own   = 0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (alu_own) own++;
      if (done) begin
        lat = c;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if ({busy, done, alu_own} !== 3'b000) $display("FAIL reset_status: got %b expected 000", {busy, done, alu_own});
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    else pass_cnt++;
    total_cnt++;
    if ({alu_a, alu_b, alu_f} !== {64'h0, ALU_CTL_ADD}) $display("FAIL reset_alu: got %h/%h/%b expected 0/0/%b", alu_a, alu_b, alu_f, ALU_CTL_ADD);
    else pass_cnt++;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_unsigned_basic();
    int lat, own;
    run_mult(32'd3, 32'd5, 1'b0, lat, own);
    total_cnt++;
    if (lat !== 34) $display("FAIL basic_latency: got %0d expected 34", lat);
    else pass_cnt++;
    total_cnt++;
    if (own !== 32) $display("FAIL basic_alu_own_cycles: got %0d expected 32", own);
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== {32'h0, 32'd15}) $display("FAIL basic_product: got %h_%h expected 0_0000000f", hi, lo);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL basic_done_pulse: got done,busy=%b expected 00", {done, busy});
    else pass_cnt++;
  endtask

  task automatic test_unsigned_max();
    int lat, own;
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, own);
    total_cnt++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001 || lat !== 34) $display("FAIL umax_product: got %h_%h lat %0d expected fffffffe_00000001 lat 34", hi, lo, lat);
    else pass_cnt++;
    step();
  endtask

  task automatic test_signed();
    int lat, own;
    run_mult(32'hFFFF_FFF9, 32'd3, 1'b1, lat, own);
    total_cnt++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || lat !== 34) $display("FAIL signed_m7x3: got %h_%h lat %0d expected ffffffff_ffffffeb lat 34", hi, lo, lat);
    else pass_cnt++;
    step();
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, lat, own);
    total_cnt++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000) $display("FAIL signed_min_sq: got %h_%h expected 40000000_00000000", hi, lo);
    else pass_cnt++;
    step();
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, own);
    total_cnt++;
    if ({hi, lo} !== 64'h0000_0000_0000_0001) $display("FAIL signed_m1xm1: got %h_%h expected 00000000_00000001", hi, lo);
    else pass_cnt++;
    step();
  endtask

  task automatic test_abort();
    int lat, own, dones;
    run_mult(32'd6, 32'd7, 1'b0, lat, own);
    total_cnt++;
    if ({hi, lo} !== {32'h0, 32'd42}) $display("FAIL abort_first_product: got %h_%h expected 0_0000002a", hi, lo);
    else pass_cnt++;
    step();
    src_a = 32'd9;
    src_b = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    total_cnt++;
    if ({busy, alu_own} !== 2'b11) $display("FAIL abort_running: got busy,alu_own=%b expected 11", {busy, alu_own});
    else pass_cnt++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    total_cnt++;
    if ({busy, alu_own} !== 2'b00) $display("FAIL abort_release: got busy,alu_own=%b expected 00", {busy, alu_own});
    else pass_cnt++;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      step();
    end
    total_cnt++;
    if (dones !== 0 || {hi, lo} !== {32'h0, 32'd42}) $display("FAIL abort_result_kept: got dones %0d %h_%h expected 0 0_0000002a", dones, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int dones;
    src_a = 32'd11;
    src_b = 32'd13;
    sgn   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 45; c++) begin
      if (done) dones++;
      if (c == 5 || c == 20) begin
        src_a = 32'd100;
        src_b = 32'd100;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    total_cnt++;
    if (dones !== 1) $display("FAIL busy_start_dones: got %0d expected 1", dones);
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== {32'h0, 32'd143}) $display("FAIL busy_start_product: got %h_%h expected 0_0000008f", hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    total_cnt++;
    if ({busy, alu_own} !== 2'b00) $display("FAIL idle_start_abort: got busy,alu_own=%b expected 00", {busy, alu_own});
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_run();
    int lat, own;
    src_a = 32'd5;
    src_b = 32'd5;
    sgn   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({busy, alu_own, done} !== 3'b000) $display("FAIL midreset_status: got busy,alu_own,done=%b expected 000", {busy, alu_own, done});
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== 64'h0) $display("FAIL midreset_hilo: got %h_%h expected 0_0", hi, lo);
    else pass_cnt++;
    step();
    rst = 1'b1;
    step();
    run_mult(32'd2, 32'd2, 1'b0, lat, own);
    total_cnt++;
    if (lat !== 34 || {hi, lo} !== {32'h0, 32'd4}) $display("FAIL midreset_rerun: got lat %0d %h_%h expected lat 34 0_00000004", lat, hi, lo);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_unsigned_max();
    test_signed();
    test_abort();
    test_start_while_busy();
    test_start_abort_idle();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
